// File: rtl/taxi_trip_ctrl.sv
// taxi_trip_ctrl -- trip-level controller for the taxi meter.
//
// Turns the start / pause / stop push-buttons into the 2-bit trip state that
// drives the distance counter and fare logic, times passenger waiting in BCD
// mm:ss, counts completed trips and flags each trip completion.
//
// Ports:
//   clk        in   1   system clock (100 Hz nominal)
//   rst_n      in   1   asynchronous active-low reset
//   btn_start  in   1   raw start button level, asynchronous to clk
//   btn_pause  in   1   raw pause button level, asynchronous to clk
//   btn_stop   in   1   raw stop button level, asynchronous to clk
//   state      out  2   trip state: IDLE=00, MOVE=01, WAIT=11 (FSM state register)
//   wait_time  out  16  wait time this trip, BCD {tens-min, min, tens-sec, sec}
//   trip_count out  8   completed trips, binary, wraps 255 -> 0
//   trip_end   out  1   completion strobe
//
// Output strobe: trip_end is a valid-only strobe (there is no ready). It is
// high for exactly one cycle on each MOVE/WAIT -> IDLE transition; trip_count
// and wait_time are stable and describe the finished trip during that cycle.
module taxi_trip_ctrl #(
    parameter int TICKS_PER_SEC  = 100,
    parameter int WAIT_TIMEOUT_S = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        btn_stop,
    output logic [1:0]  state,
    output logic [15:0] wait_time,
    output logic [7:0]  trip_count,
    output logic        trip_end
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    // Seconds-in-episode counter: at least 13 bits, wide enough for the timeout.
    localparam int SW = ($clog2(WAIT_TIMEOUT_S + 1) > 13) ? $clog2(WAIT_TIMEOUT_S + 1) : 13;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_MAX  = '1;
    localparam logic [SW-1:0] TIMEOUT  = SW'(WAIT_TIMEOUT_S);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MOVE = 2'b01,
        ST_WAIT = 2'b11
    } state_t;

    // ---------------- button synchronisers and rising-edge detect ----------
    // Bit order everywhere: {stop, pause, start}.
    logic [2:0] btn_raw;
    logic [2:0] btn_s1, btn_s2, btn_p;
    logic [2:0] btn_ev;

    assign btn_raw = {btn_stop, btn_pause, btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_p  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            btn_p  <= btn_s2;
        end
    end

    // One event per press, however long the button is held.
    assign btn_ev = btn_s2 & ~btn_p;

    // ---------------- trip FSM ---------------------------------------------
    state_t          state_q, state_d;
    logic [PW-1:0]   prescaler;
    logic [SW-1:0]   sec_cnt;
    logic            clr_all;     // IDLE -> MOVE: new trip, clear the wait timer
    logic            clr_ep;      // MOVE -> WAIT: new waiting episode
    logic            end_trip;    // MOVE/WAIT -> IDLE
    logic            timeout_hit;
    logic            tick;

    assign timeout_hit = (WAIT_TIMEOUT_S != 0) && (sec_cnt == TIMEOUT);
    assign tick        = (state_q == ST_WAIT) && (prescaler == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority is stop > start > pause; events meaningless in a state are ignored.
    always_comb begin
        state_d  = state_q;
        clr_all  = 1'b0;
        clr_ep   = 1'b0;
        end_trip = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_ev[0]) begin
                    state_d = ST_MOVE;
                    clr_all = 1'b1;
                end
            end
            ST_MOVE: begin
                if (btn_ev[2]) begin
                    state_d  = ST_IDLE;
                    end_trip = 1'b1;
                end else if (btn_ev[1]) begin
                    state_d = ST_WAIT;
                    clr_ep  = 1'b1;
                end
            end
            ST_WAIT: begin
                // A timeout is handled exactly like a stop press.
                if (btn_ev[2] || timeout_hit) begin
                    state_d  = ST_IDLE;
                    end_trip = 1'b1;
                end else if (btn_ev[0] || btn_ev[1]) begin
                    state_d = ST_MOVE;
                end
            end
            default: begin
                // Illegal encoding 2'b10: recover silently, no trip_end.
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state = state_q;

    // ---------------- wait timer -------------------------------------------
    // One-second BCD increment with carry sec -> tens-sec (0..5) -> min ->
    // tens-min, saturating at 99:59.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v == 16'h9959) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // The prescaler only runs in WAIT and holds in MOVE, so a fractional
    // second carries across pause/resume within one trip. Values are kept on
    // entry to IDLE so the fare display can still read the last trip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            sec_cnt   <= '0;
            wait_time <= '0;
        end else if (clr_all) begin
            prescaler <= '0;
            sec_cnt   <= '0;
            wait_time <= '0;
        end else begin
            if (state_q == ST_WAIT) begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
            end
            if (clr_ep) begin
                sec_cnt <= '0;
            end else if (tick && (sec_cnt != SEC_MAX)) begin
                sec_cnt <= sec_cnt + SW'(1);
            end
            if (tick) begin
                wait_time <= bcd_inc(wait_time);
            end
        end
    end

    // ---------------- trip completion --------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trip_end   <= 1'b0;
            trip_count <= '0;
        end else begin
            trip_end <= end_trip;
            if (end_trip) begin
                trip_count <= trip_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Testbench for taxi_trip_ctrl. Three instances with different timing
// parameters share the same buttons and reset. A reference model predicts,
// per instance, every state change, wait-time change and trip completion
// with the edge number at which it must appear; a monitor on the falling
// edge pops those predictions whenever the DUT presents a change or a
// trip_end strobe and compares value and timing.
module tb_taxi_trip_ctrl;

    localparam int N = 3;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MOVE = 2'b01;
    localparam logic [1:0] S_WAIT = 2'b11;
    localparam logic [2:0] B_START = 3'b001;
    localparam logic [2:0] B_PAUSE = 3'b010;
    localparam logic [2:0] B_STOP  = 3'b100;

    function automatic int tps_of(input int i);
        return (i == 0) ? 100 : 2;
    endfunction

    function automatic int to_of(input int i);
        return (i == 0) ? 600 : ((i == 1) ? 0 : 3);
    endfunction

    // ---------------- clock / reset / DUTs ---------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_start = 1'b0;
    logic btn_pause = 1'b0;
    logic btn_stop = 1'b0;
    logic [1:0]  st [N];
    logic [15:0] wt [N];
    logic [7:0]  tc [N];
    logic        te [N];

    always #5 clk = ~clk;

    taxi_trip_ctrl #(.TICKS_PER_SEC(100), .WAIT_TIMEOUT_S(600)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
        .btn_stop(btn_stop), .state(st[0]), .wait_time(wt[0]),
        .trip_count(tc[0]), .trip_end(te[0]));

    taxi_trip_ctrl #(.TICKS_PER_SEC(2), .WAIT_TIMEOUT_S(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
        .btn_stop(btn_stop), .state(st[1]), .wait_time(wt[1]),
        .trip_count(tc[1]), .trip_end(te[1]));

    taxi_trip_ctrl #(.TICKS_PER_SEC(2), .WAIT_TIMEOUT_S(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
        .btn_stop(btn_stop), .state(st[2]), .wait_time(wt[2]),
        .trip_count(tc[2]), .trip_end(te[2]));

    // Rising-edge counter used to timestamp predictions.
    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    // ---------------- reference model --------------------------------------
    // Wait time of a trip = (cycles spent in WAIT since the trip started) /
    // ticks-per-second, shown as mm:ss, capped at 99:59. Seconds in the
    // current episode = whole seconds completed since entering WAIT.
    logic [33:0] sq [N][$];   // {edge, state}
    logic [47:0] wq [N][$];   // {edge, wait_time}
    logic [55:0] tq [N][$];   // {edge, trip_count, wait_time}

    logic [1:0] m_st [N];
    int         m_w [N];
    int         m_base [N];
    int         m_cnt [N];
    logic [2:0] lv0, lv1, lv2, lv3;   // button level at this edge and 1..3 edges back

    function automatic logic [15:0] to_bcd(input int w, input int tps);
        int s;
        int m;
        s = w / tps;
        if (s > 5999) s = 5999;
        m = s / 60;
        s = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            m_st[i] = S_IDLE; m_w[i] = 0; m_base[i] = 0; m_cnt[i] = 0;
        end
        lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0;
                for (int i = 0; i < N; i++) begin
                    m_st[i] = S_IDLE; m_w[i] = 0; m_base[i] = 0; m_cnt[i] = 0;
                    sq[i].delete(); wq[i].delete(); tq[i].delete();
                end
            end else begin
                logic [31:0] t;
                logic [2:0]  ev;
                t = 32'(pcnt + 1);
                lv3 = lv2; lv2 = lv1; lv1 = lv0;
                lv0 = {btn_stop, btn_pause, btn_start};
                // A press sampled at edge k acts at edge k+2, once per press.
                ev = lv2 & ~lv3;
                for (int i = 0; i < N; i++) begin
                    logic [1:0]  cur, nxt;
                    logic        trip, tmo;
                    logic [15:0] old_wt, new_wt;
                    int          secs;
                    cur = m_st[i];
                    nxt = cur;
                    trip = 1'b0;
                    old_wt = to_bcd(m_w[i], tps_of(i));
                    secs = m_w[i] / tps_of(i) - m_base[i] / tps_of(i);
                    tmo = (to_of(i) != 0) && (secs == to_of(i));
                    if (cur == S_IDLE) begin
                        if (ev[0]) nxt = S_MOVE;
                    end else if (cur == S_MOVE) begin
                        if (ev[2]) begin nxt = S_IDLE; trip = 1'b1; end
                        else if (ev[1]) nxt = S_WAIT;
                    end else begin
                        if (ev[2] || tmo) begin nxt = S_IDLE; trip = 1'b1; end
                        else if (ev[0] || ev[1]) nxt = S_MOVE;
                    end
                    if (cur == S_WAIT) m_w[i] = m_w[i] + 1;
                    if (cur == S_IDLE && nxt == S_MOVE) begin m_w[i] = 0; m_base[i] = 0; end
                    if (cur == S_MOVE && nxt == S_WAIT) m_base[i] = m_w[i];
                    new_wt = to_bcd(m_w[i], tps_of(i));
                    if (nxt != cur) sq[i].push_back({t, nxt});
                    if (new_wt != old_wt) wq[i].push_back({t, new_wt});
                    if (trip) begin
                        m_cnt[i] = (m_cnt[i] + 1) % 256;
                        tq[i].push_back({t, 8'(m_cnt[i]), new_wt});
                    end
                    m_st[i] = nxt;
                end
            end
        end
    end

    // ---------------- scoreboard monitor -----------------------------------
    int n_chk = 0;
    int n_fail = 0;
    logic [1:0]  prev_st [N];
    logic [15:0] prev_wt [N];

    task automatic check(input string name, input int i, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h required %0h (edge %0d)", i, name, act, req, pcnt);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            prev_st[i] = S_IDLE; prev_wt[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    check("reset state", i, 64'(st[i]), 64'(S_IDLE));
                    check("reset wait_time", i, 64'(wt[i]), 64'h0);
                    check("reset trip_count", i, 64'(tc[i]), 64'h0);
                    check("reset trip_end", i, 64'(te[i]), 64'h0);
                    prev_st[i] = S_IDLE;
                    prev_wt[i] = '0;
                end else begin
                    logic [33:0] es;
                    logic [47:0] ew;
                    logic [55:0] et;
                    // Predictions older than this edge were never observed.
                    while (sq[i].size() > 0 && int'(sq[i][0][33:2]) < pcnt) begin
                        es = sq[i].pop_front();
                        check("state change missing", i, 64'(st[i]), 64'(es[1:0]));
                        if (st[i] === es[1:0]) check("state change missing edge", i, 64'(pcnt), 64'(es[33:2]));
                    end
                    while (wq[i].size() > 0 && int'(wq[i][0][47:16]) < pcnt) begin
                        ew = wq[i].pop_front();
                        check("wait_time change missing", i, 64'(wt[i]), 64'(ew[15:0]));
                        if (wt[i] === ew[15:0]) check("wait_time change missing edge", i, 64'(pcnt), 64'(ew[47:16]));
                    end
                    while (tq[i].size() > 0 && int'(tq[i][0][55:24]) < pcnt) begin
                        et = tq[i].pop_front();
                        check("trip_end missing", i, 64'(te[i]), 64'h1);
                    end
                    if (st[i] !== prev_st[i]) begin
                        if (sq[i].size() == 0) begin
                            check("state unexpected change", i, 64'(st[i]), 64'(prev_st[i]));
                        end else begin
                            es = sq[i].pop_front();
                            check("state", i, 64'(st[i]), 64'(es[1:0]));
                            check("state edge", i, 64'(pcnt), 64'(es[33:2]));
                        end
                    end
                    prev_st[i] = st[i];
                    if (wt[i] !== prev_wt[i]) begin
                        if (wq[i].size() == 0) begin
                            check("wait_time unexpected change", i, 64'(wt[i]), 64'(prev_wt[i]));
                        end else begin
                            ew = wq[i].pop_front();
                            check("wait_time", i, 64'(wt[i]), 64'(ew[15:0]));
                            check("wait_time edge", i, 64'(pcnt), 64'(ew[47:16]));
                        end
                    end
                    prev_wt[i] = wt[i];
                    if (te[i] === 1'b1) begin
                        if (tq[i].size() == 0) begin
                            check("trip_end unexpected", i, 64'(te[i]), 64'h0);
                        end else begin
                            et = tq[i].pop_front();
                            check("trip count/wait", i, {40'h0, tc[i], wt[i]}, {40'h0, et[23:0]});
                            check("trip_end edge", i, 64'(pcnt), 64'(et[55:24]));
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks -----------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [2:0] b, input int hold, input int gap);
        {btn_stop, btn_pause, btn_start} = b;
        step(hold);
        {btn_stop, btn_pause, btn_start} = 3'b000;
        step(gap);
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        step(3);
        rst_n = 1'b1;
        step(2);

        // Start a trip; pause for 250 cycles, resume; pause again and press
        // all three buttons together in WAIT.
        press(B_START, 1, 10);
        press(B_PAUSE, 1, 249);
        press(B_PAUSE, 1, 10);
        press(B_PAUSE, 1, 10);
        press(3'b111, 1, 10);

        // Short trip with a wait long enough for the 3 s timeout instance.
        press(B_START, 1, 5);
        press(B_PAUSE, 1, 30);
        press(B_STOP, 1, 5);
        press(B_START, 1, 5);
        press(B_STOP, 1, 5);

        // Long wait past 99:59 on the 2-tick instances.
        press(B_START, 1, 5);
        press(B_PAUSE, 1, 12100);
        press(B_STOP, 1, 10);

        // Held pause gives a single transition; then reset in the middle of WAIT.
        press(B_START, 1, 5);
        press(B_PAUSE, 20, 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        // Enough quick trips to wrap trip_count.
        repeat (260) begin
            press(B_START, 1, 3);
            press(B_STOP, 1, 3);
        end

        // Random single-button presses.
        repeat (80) begin
            press(3'(1 << $urandom_range(0, 2)), $urandom_range(1, 8), $urandom_range(2, 40));
        end

        step(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
